calc_abs_rtan_seq: RTL and testbench

- Sequential, parametrised engine that computes |r·tan(θk)| for θk = k·STEP_DEG, k = 0..NUM_ANGLES-1.
- Replaces per-angle combinational multipliers with one shared multiplier and a tangent ROM.
- Streams one result per angle over a valid/ready handshake, with a sign flag and saturation flag instead of a blind truncating cast.
- Sits between the polar target-position logic and the display/coordinate conversion path.

---
 rtl/calc_abs_rtan_seq_pkg.sv | 49 ++++
 rtl/calc_abs_rtan_seq_abs_round_sat.sv | 29 ++
 rtl/calc_abs_rtan_seq.sv | 131 +++++++++++++
 tb/tb_calc_abs_rtan_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_abs_rtan_seq_pkg.sv
// calc_abs_rtan_seq_pkg: shared types and constants for the |r*tan(theta)| engine.
// Holds the FSM encoding, the 15-degree tangent ROM (Q.8) and the legal angle steps.
package calc_abs_rtan_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam int ROM_FRAC = 8;
    localparam int ROM_STEP = 15;
    localparam int ROM_90   = 6;

    function automatic bit step_legal(input int s);
        return (s == 15) || (s == 30) || (s == 45);
    endfunction

    function automatic logic [31:0] tan_q8(input int i);
        logic [31:0] v;
        case (i)
            0:       v = 32'd0;
            1:       v = 32'd69;
            2:       v = 32'd148;
            3:       v = 32'd256;
            4:       v = 32'd443;
            5:       v = 32'd955;
            default: v = '1;
        endcase
        return v;
    endfunction

    // Entry i covers 15*i degrees, rescaled to frac fractional bits.
    // The 90-degree slot returns all ones so |r|*tan is nonzero for any
    // r != 0; the magnitude itself is forced saturated downstream.
    function automatic logic [31:0] tan_rom(input int i, input int frac);
        logic [31:0] v;
        v = tan_q8(i);
        if (i >= ROM_90) begin
            v = '1;
        end else if (frac >= ROM_FRAC) begin
            v = v << (frac - ROM_FRAC);
        end else begin
            v = v >> (ROM_FRAC - frac);
        end
        return v;
    endfunction

endpackage

// File: rtl/calc_abs_rtan_seq_abs_round_sat.sv
// calc_abs_rtan_seq_abs_round_sat: round-half-up, clamp and sign flag for a
// fixed-point magnitude. Ports: mag_in/neg_in/force_sat in; mag/neg/sat out.
module calc_abs_rtan_seq_abs_round_sat #(
    parameter int IN_W  = 21,
    parameter int FRAC  = 8,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  mag_in,
    input  logic             neg_in,
    input  logic             force_sat,
    output logic [OUT_W-1:0] mag,
    output logic             neg,
    output logic             sat
);

    localparam int RES_W = IN_W - FRAC + 1;
    localparam logic [IN_W:0] HALF = (IN_W + 1)'(1) << (FRAC - 1);

    logic [RES_W-1:0] res;
    logic             over;

    assign res  = RES_W'(({1'b0, mag_in} + HALF) >> FRAC);
    assign over = |res[RES_W-1:OUT_W];
    assign sat  = over || force_sat;
    assign mag  = sat ? '1 : res[OUT_W-1:0];
    // Sign only reported when the unsaturated magnitude is nonzero.
    assign neg  = neg_in && (res != '0);

endmodule

// File: rtl/calc_abs_rtan_seq.sv
// calc_abs_rtan_seq: sequential |r*tan(k*STEP_DEG)| sweep, one shared multiplier.
// In: clock, reset_n, start, r, out_ready. Out: busy, out_valid, out_idx,
// out_mag, out_neg, out_sat, done (pulse on acceptance of the last angle).
module calc_abs_rtan_seq
    import calc_abs_rtan_seq_pkg::*;
#(
    parameter int R_WIDTH    = 9,
    parameter int OUT_WIDTH  = 8,
    parameter int TAN_FRAC   = 8,
    parameter int STEP_DEG   = 15,
    parameter int NUM_ANGLES = 6,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic signed [R_WIDTH-1:0] r,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_WIDTH-1:0]      out_idx,
    output logic [OUT_WIDTH-1:0]      out_mag,
    output logic                      out_neg,
    output logic                      out_sat,
    output logic                      done
);

    localparam int TAN_W  = TAN_FRAC + 4;
    localparam int PROD_W = R_WIDTH + TAN_W;
    localparam int LAST   = NUM_ANGLES - 1;

    if (!step_legal(STEP_DEG)) begin : g_bad_step
        $error("STEP_DEG must be 15, 30 or 45");
    end

    state_t state_q;
    state_t state_d;

    logic [R_WIDTH-1:0]   absr_q;
    logic                 rneg_q;
    logic [IDX_WIDTH-1:0] k_q;

    logic [TAN_W-1:0]     tan_k;
    logic [PROD_W-1:0]    prod;
    logic                 is90;
    logic [OUT_WIDTH-1:0] mag_c;
    logic                 neg_c;
    logic                 sat_c;

    logic take;
    logic accept;
    logic last;

    assign take   = (state_q == ST_IDLE) && start;
    assign accept = out_valid && out_ready;
    assign last   = (k_q == IDX_WIDTH'(LAST));
    assign done   = accept && last;
    assign busy   = (state_q != ST_IDLE);

    // Shared multiplier: operands come straight from registers so the
    // product is formed during CALC and captured into out_* on entry to OUT.
    assign tan_k = TAN_W'(tan_rom(int'(k_q) * (STEP_DEG / ROM_STEP), TAN_FRAC));
    assign is90  = (int'(k_q) * STEP_DEG) == 90;
    assign prod  = PROD_W'(absr_q) * PROD_W'(tan_k);

    calc_abs_rtan_seq_abs_round_sat #(
        .IN_W  (PROD_W),
        .FRAC  (TAN_FRAC),
        .OUT_W (OUT_WIDTH)
    ) u_ars (
        .mag_in    (prod),
        .neg_in    (rneg_q),
        .force_sat (is90),
        .mag       (mag_c),
        .neg       (neg_c),
        .sat       (sat_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_CALC;
            ST_CALC: state_d = ST_OUT;
            ST_OUT:  if (accept) state_d = last ? ST_IDLE : ST_CALC;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            absr_q    <= '0;
            rneg_q    <= 1'b0;
            k_q       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_mag   <= '0;
            out_neg   <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            if (take) begin
                // -r wraps into the unsigned width, so the most
                // negative r yields 2^(R_WIDTH-1) as required.
                absr_q <= r[R_WIDTH-1] ? -r : r;
                rneg_q <= r[R_WIDTH-1];
                k_q    <= '0;
            end
            if (state_q == ST_CALC) begin
                out_valid <= 1'b1;
                out_idx   <= k_q;
                out_mag   <= mag_c;
                out_neg   <= neg_c;
                out_sat   <= sat_c;
            end
            if (accept) begin
                out_valid <= 1'b0;
                if (!last) begin
                    k_q <= k_q + IDX_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_abs_rtan_seq.sv
// tb_calc_abs_rtan_seq: randomized and directed checks of calc_abs_rtan_seq
// against an arithmetic reference model (two parameter sets).
module tb_calc_abs_rtan_seq;

    localparam int RW = 9;
    localparam int OW = 8;
    localparam int IW = 3;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;

    logic          start = 1'b0;
    logic signed [RW-1:0] r = '0;
    logic          out_ready = 1'b0;
    logic          busy, out_valid, out_neg, out_sat, done;
    logic [IW-1:0] out_idx;
    logic [OW-1:0] out_mag;

    logic          start2 = 1'b0;
    logic signed [RW-1:0] r2 = '0;
    logic          ready2 = 1'b0;
    logic          busy2, out_valid2, out_neg2, out_sat2, done2;
    logic [IW-1:0] out_idx2;
    logic [OW-1:0] out_mag2;

    int vectors = 0;
    int errors  = 0;
    int got30[4];

    always #5 clock = ~clock;

    calc_abs_rtan_seq dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .r         (r),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_mag   (out_mag),
        .out_neg   (out_neg),
        .out_sat   (out_sat),
        .done      (done)
    );

    calc_abs_rtan_seq #(
        .STEP_DEG   (30),
        .NUM_ANGLES (4)
    ) dut30 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start2),
        .r         (r2),
        .busy      (busy2),
        .out_valid (out_valid2),
        .out_ready (ready2),
        .out_idx   (out_idx2),
        .out_mag   (out_mag2),
        .out_neg   (out_neg2),
        .out_sat   (out_sat2),
        .done      (done2)
    );

    function automatic int tanq8(input int deg);
        case (deg)
            0:       return 0;
            15:      return 69;
            30:      return 148;
            45:      return 256;
            60:      return 443;
            default: return 955;
        endcase
    endfunction

    // |r*tan(theta)| rounded half up, clamped to 255; 90 degrees saturates.
    function automatic void model(input int rv, input int theta,
                                  output int mag, output bit neg,
                                  output bit sat);
        int a;
        int res;
        a = (rv < 0) ? -rv : rv;
        if (theta == 90) begin
            mag = 255;
            sat = 1'b1;
            neg = (rv < 0);
        end else begin
            res = (a * tanq8(theta) + 128) / 256;
            sat = (res > 255);
            mag = sat ? 255 : res;
            neg = (rv < 0) && (res != 0);
        end
    endfunction

    task automatic sweep(input int rv, input int stall_pct, input bit noise);
        int k;
        int cyc;
        int em;
        bit en;
        bit es;
        bit acc;
        @(negedge clock);
        r = RW'(rv);
        start = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        cyc = 1;
        while (k < 6 && cyc < 400) begin
            if (noise) begin
                start = 1'($urandom);
                r = RW'($urandom);
            end
            out_ready = ($urandom_range(99) >= stall_pct);
            #1;
            acc = out_valid && out_ready;
            vectors++;
            if (busy !== 1'b1 || done !== (acc && k == 5)) begin
                errors++;
                $display("FAIL sweep_ctrl r=%0d cyc=%0d busy=%b done=%b want busy=1 done=%b",
                         rv, cyc, busy, done, acc && k == 5);
            end
            if (stall_pct == 0) begin
                vectors++;
                if (out_valid !== (cyc % 2 == 0)) begin
                    errors++;
                    $display("FAIL sweep_timing r=%0d cyc=%0d valid=%b want %b",
                             rv, cyc, out_valid, (cyc % 2 == 0));
                end
            end
            if (acc) begin
                model(rv, k * 15, em, en, es);
                vectors++;
                if (out_idx !== IW'(k) || out_mag !== OW'(em) ||
                    out_neg !== en || out_sat !== es) begin
                    errors++;
                    $display("FAIL sweep_data r=%0d got idx=%0d mag=%0d neg=%b sat=%b want idx=%0d mag=%0d neg=%b sat=%b",
                             rv, out_idx, out_mag, out_neg, out_sat, k, em, en, es);
                end
                k++;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (k != 6) begin
            errors++;
            $display("FAIL sweep_timeout r=%0d got %0d results want 6", rv, k);
        end else if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL sweep_idle r=%0d busy=%b valid=%b done=%b want 0 0 0",
                     rv, busy, out_valid, done);
        end
    endtask

    task automatic sweep30(input int rv);
        int k;
        int cyc;
        int em;
        bit en;
        bit es;
        @(negedge clock);
        r2 = RW'(rv);
        start2 = 1'b1;
        ready2 = 1'b1;
        @(negedge clock);
        start2 = 1'b0;
        k = 0;
        cyc = 1;
        while (k < 4 && cyc < 100) begin
            #1;
            vectors++;
            if (out_valid2 !== (cyc % 2 == 0) || done2 !== (cyc == 8)) begin
                errors++;
                $display("FAIL s30_timing r=%0d cyc=%0d valid=%b done=%b want %b %b",
                         rv, cyc, out_valid2, done2, (cyc % 2 == 0), (cyc == 8));
            end
            if (out_valid2 === 1'b1) begin
                model(rv, k * 30, em, en, es);
                vectors++;
                if (out_idx2 !== IW'(k) || out_mag2 !== OW'(em) ||
                    out_neg2 !== en || out_sat2 !== es) begin
                    errors++;
                    $display("FAIL s30_data r=%0d got idx=%0d mag=%0d neg=%b sat=%b want idx=%0d mag=%0d neg=%b sat=%b",
                             rv, out_idx2, out_mag2, out_neg2, out_sat2, k, em, en, es);
                end
                got30[k] = int'(out_mag2);
                k++;
            end
            @(negedge clock);
            cyc++;
        end
        vectors++;
        if (k != 4 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL s30_end r=%0d results=%0d busy=%b want 4 0", rv, k, busy2);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({busy, out_valid, done, out_neg, out_sat, out_idx, out_mag} !== '0 ||
            {busy2, out_valid2, done2, out_neg2, out_sat2, out_idx2, out_mag2} !== '0) begin
            errors++;
            $display("FAIL reset_state dut=%h dut30=%h want 0",
                     {busy, out_valid, done, out_neg, out_sat, out_idx, out_mag},
                     {busy2, out_valid2, done2, out_neg2, out_sat2, out_idx2, out_mag2});
        end
        reset_n = 1'b1;
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_directed;
        sweep(100, 0, 1'b0);
        sweep(-100, 0, 1'b0);
        sweep(-256, 0, 1'b0);
        sweep(255, 0, 1'b0);
        sweep(0, 0, 1'b0);
        sweep(-1, 0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 25; i++) begin
            sweep(int'($urandom_range(511)) - 256,
                  int'($urandom_range(60)), 1'($urandom));
        end
    endtask

    task automatic test_stall;
        int n;
        @(negedge clock);
        r = RW'(100);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(out_valid === 1'b1 && out_idx === IW'(2)) && n < 50) begin
            @(negedge clock);
            n++;
        end
        out_ready = 1'b0;
        vectors++;
        if (n >= 50) begin
            errors++;
            $display("FAIL stall_reach idx2 not seen within %0d cycles", n);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if (out_valid !== 1'b1 || out_mag !== OW'(58) || out_idx !== IW'(2)) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d valid=%b mag=%0d idx=%0d want 1 58 2",
                         i, out_valid, out_mag, out_idx);
            end
        end
        out_ready = 1'b1;
        @(negedge clock);
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drop valid=%b want 0", out_valid);
        end
        @(negedge clock);
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== IW'(3) || out_mag !== OW'(100)) begin
            errors++;
            $display("FAIL stall_next valid=%b idx=%0d mag=%0d want 1 3 100",
                     out_valid, out_idx, out_mag);
        end
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (n >= 50) begin
            errors++;
            $display("FAIL stall_done no done within %0d cycles", n);
        end
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_step30;
        sweep30(50);
        vectors++;
        if (got30[0] != 0 || got30[1] != 29 || got30[2] != 87 || got30[3] != 255) begin
            errors++;
            $display("FAIL s30_table got %0d %0d %0d %0d want 0 29 87 255",
                     got30[0], got30[1], got30[2], got30[3]);
        end
        for (int i = 0; i < 6; i++) begin
            sweep30(int'($urandom_range(511)) - 256);
        end
        sweep30(-256);
    endtask

    task automatic test_reset_mid;
        int n;
        @(negedge clock);
        r = RW'(-100);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(out_valid === 1'b1 && out_idx === IW'(2)) && n < 50) begin
            @(negedge clock);
            n++;
        end
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (n >= 50 ||
            {busy, out_valid, done, out_neg, out_sat, out_idx, out_mag} !== '0) begin
            errors++;
            $display("FAIL reset_mid n=%0d outs=%h want 0", n,
                     {busy, out_valid, done, out_neg, out_sat, out_idx, out_mag});
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle busy=%b done=%b want 0 0", busy, done);
        end
        sweep(10, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_step30();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
